// File: rtl/adder_bist_pkg.sv
// Shared types and width helpers for the adder BIST engine.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } bist_state_e;

  function automatic int unsigned idx_w(input int unsigned nvec);
    return (nvec > 1) ? $clog2(nvec) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned nvec);
    return $clog2(nvec * nvec) + 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(16);
  localparam int unsigned CNT_W = cnt_w(16);

endpackage

// File: rtl/adder_bist_engine_vec_ram.sv
// Operand table: one synchronous write port, two asynchronous read ports.
module bist_vec_ram
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NVEC  = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [idx_w(NVEC)-1:0]  waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [idx_w(NVEC)-1:0]  raddr_a,
  output logic [WIDTH-1:0]        rdata_a,
  input  logic [idx_w(NVEC)-1:0]  raddr_b,
  output logic [WIDTH-1:0]        rdata_b
);

  logic [WIDTH-1:0] mem [NVEC];

  // No reset: table contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/adder_bist_engine.sv
// Exhaustive ordered-pair sweep of an external adder: apply, settle, compare, log first failure.
module adder_bist_engine
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NVEC   = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cin,
  input  logic                    vec_we,
  input  logic [idx_w(NVEC)-1:0]  vec_addr,
  input  logic [WIDTH-1:0]        vec_data,
  output logic [WIDTH-1:0]        dut_a,
  output logic [WIDTH-1:0]        dut_b,
  output logic                    dut_cin,
  input  logic [WIDTH-1:0]        dut_s,
  input  logic                    dut_cout,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [cnt_w(NVEC)-1:0]  err_count,
  output logic                    err_pulse,
  output logic [WIDTH-1:0]        first_a,
  output logic [WIDTH-1:0]        first_b,
  output logic [WIDTH:0]          first_exp,
  output logic [WIDTH:0]          first_got
);

  localparam int unsigned IW = idx_w(NVEC);
  localparam int unsigned CW = cnt_w(NVEC);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  bist_state_e      state;
  logic [IW-1:0]    idx_i;
  logic [IW-1:0]    idx_j;
  logic             cin_q;
  logic [WIDTH:0]   exp_q;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             ram_we;
  logic [WIDTH:0]   got;
  logic             mismatch;
  logic             i_last;
  logic             j_last;

  assign ram_we   = vec_we && ((state == IDLE) || (state == DONE));
  assign got      = {dut_cout, dut_s};
  assign mismatch = (got != exp_q);
  assign i_last   = (idx_i == IW'(NVEC - 1));
  assign j_last   = (idx_j == IW'(NVEC - 1));

  bist_vec_ram #(
    .WIDTH (WIDTH),
    .NVEC  (NVEC)
  ) u_vec_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (vec_addr),
    .wdata   (vec_data),
    .raddr_a (idx_i),
    .rdata_a (rd_a),
    .raddr_b (idx_j),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx_i      <= '0;
      idx_j      <= '0;
      cin_q      <= 1'b0;
      exp_q      <= '0;
      settle_cnt <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_cin    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      err_pulse  <= 1'b0;
      first_a    <= '0;
      first_b    <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (err_count == '0);
          end
          // Later assignments here override the DONE bookkeeping above.
          if (start) begin
            idx_i     <= '0;
            idx_j     <= '0;
            err_count <= '0;
            first_a   <= '0;
            first_b   <= '0;
            first_exp <= '0;
            first_got <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            cin_q     <= cin;
            state     <= APPLY;
          end
        end
        APPLY: begin
          dut_a      <= rd_a;
          dut_b      <= rd_b;
          dut_cin    <= cin_q;
          exp_q      <= {1'b0, rd_a} + {1'b0, rd_b} + {{WIDTH{1'b0}}, cin_q};
          settle_cnt <= SW'(SETTLE - 1);
          state      <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_pulse <= 1'b1;
            if (!(&err_count)) begin
              err_count <= err_count + CW'(1);
            end
            // Count never wraps, so zero means nothing captured yet.
            if (err_count == '0) begin
              first_a   <= dut_a;
              first_b   <= dut_b;
              first_exp <= exp_q;
              first_got <= got;
            end
          end
          if (j_last) begin
            idx_j <= '0;
            if (i_last) begin
              state <= DONE;
            end else begin
              idx_i <= idx_i + IW'(1);
              state <= APPLY;
            end
          end else begin
            idx_j <= idx_j + IW'(1);
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
